updown_dir_ctrl: RTL and testbench

//  Upstream direction controller for the 5-bit up/down ripple counter. Samples the counter's

---
 rtl/updown_dir_ctrl_if.sv | 25 ++
 rtl/updown_dir_ctrl.sv | 127 ++++++++++++
 tb/tb_updown_dir_ctrl.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/updown_dir_ctrl_if.sv
// Bus between the sweep direction controller and its user: limits, enable and count in,
// direction, flip pulse, sweep count and limit error out.
interface updown_dir_ctrl_if #(
  parameter int WIDTH   = 5,
  parameter int SWEEP_W = 8
);
  logic               enable;
  logic [WIDTH-1:0]   lo_lim;
  logic [WIDTH-1:0]   hi_lim;
  logic [WIDTH-1:0]   count;
  logic               up_down;
  logic               dir_flip;
  logic [SWEEP_W-1:0] sweep_cnt;
  logic               limit_err;

  modport master (
    output enable, lo_lim, hi_lim, count,
    input  up_down, dir_flip, sweep_cnt, limit_err
  );

  modport slave (
    input  enable, lo_lim, hi_lim, count,
    output up_down, dir_flip, sweep_cnt, limit_err
  );
endinterface

// File: rtl/updown_dir_ctrl.sv
// Direction controller sweeping an up/down ripple counter between lo_lim and hi_lim.
// Optional macro STEP_CHECK_EN rejects samples whose step is not 0/+1/-1 as ripple glitches.
module updown_dir_ctrl #(
  parameter int WIDTH   = 5,
  parameter int SWEEP_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  updown_dir_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]   CNT_ONES  = '1;
  localparam logic [SWEEP_W-1:0] SWEEP_MAX = '1;

  logic [WIDTH-1:0]   r_c1;
  logic [WIDTH-1:0]   r_c2;
  logic [WIDTH-1:0]   r_cur;
  state_t             r_state;
  logic               r_up_down;
  logic               r_dir_flip;
  logic [SWEEP_W-1:0] r_sweep;

  state_t             w_state_nxt;
  logic               w_up_down_nxt;
  logic               w_dir_flip_nxt;
  logic [SWEEP_W-1:0] w_sweep_nxt;
  logic [SWEEP_W-1:0] w_sweep_inc;
  logic               w_accept;
  logic               w_wrap_up;
  logic               w_wrap_dn;
  logic               w_lim_bad;

`ifdef STEP_CHECK_EN
  // A ripple counter moves by at most one count per clock; anything else is mid-ripple.
  logic [WIDTH-1:0] w_delta;
  assign w_delta  = r_c1 - r_c2;
  assign w_accept = (w_delta == '0) || (w_delta == WIDTH'(1)) || (w_delta == CNT_ONES);
`else
  assign w_accept = 1'b1;
`endif

  assign w_wrap_up   = (r_c2 == CNT_ONES) && (r_c1 == '0);
  assign w_wrap_dn   = (r_c2 == '0) && (r_c1 == CNT_ONES);
  assign w_lim_bad   = (bus.lo_lim >= bus.hi_lim);
  assign w_sweep_inc = (r_sweep == SWEEP_MAX) ? r_sweep : r_sweep + 1'b1;

  // NOTE: every signal gets a default before the decision tree, so no path can infer a latch.
  always_comb begin
    w_state_nxt    = r_state;
    w_up_down_nxt  = r_up_down;
    w_dir_flip_nxt = 1'b0;
    w_sweep_nxt    = r_sweep;

    if (!bus.enable) begin
      w_state_nxt = ST_IDLE;
    end else if (w_lim_bad) begin
      w_state_nxt = ST_ERR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_sweep_nxt = '0;
          if (r_cur < bus.hi_lim) begin
            w_state_nxt   = ST_UP;
            w_up_down_nxt = 1'b1;
          end else begin
            w_state_nxt   = ST_DOWN;
            w_up_down_nxt = 1'b0;
          end
        end
        ST_UP: begin
          if (w_accept && ((r_c1 >= bus.hi_lim) || w_wrap_up)) begin
            w_state_nxt    = ST_DOWN;
            w_up_down_nxt  = 1'b0;
            w_dir_flip_nxt = 1'b1;
            w_sweep_nxt    = w_sweep_inc;
          end
        end
        ST_DOWN: begin
          if (w_accept && ((r_c1 <= bus.lo_lim) || w_wrap_dn)) begin
            w_state_nxt    = ST_UP;
            w_up_down_nxt  = 1'b1;
            w_dir_flip_nxt = 1'b1;
            w_sweep_nxt    = w_sweep_inc;
          end
        end
        ST_ERR:  w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_c1       <= '0;
      r_c2       <= '0;
      r_cur      <= '0;
      r_state    <= ST_IDLE;
      r_up_down  <= 1'b1;
      r_dir_flip <= 1'b0;
      r_sweep    <= '0;
    end else begin
      r_c1       <= bus.count;
      r_c2       <= r_c1;
      if (w_accept) begin
        r_cur <= r_c1;
      end
      r_state    <= w_state_nxt;
      r_up_down  <= w_up_down_nxt;
      r_dir_flip <= w_dir_flip_nxt;
      r_sweep    <= w_sweep_nxt;
    end
  end

  assign bus.up_down   = r_up_down;
  assign bus.dir_flip  = r_dir_flip;
  assign bus.sweep_cnt = r_sweep;
  assign bus.limit_err = (r_state == ST_ERR);

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Bench for updown_dir_ctrl: directed scenarios plus randomized counter/glitch stimulus,
// all outputs compared every cycle against a behavioural sweep model.
module tb_updown_dir_ctrl;

  localparam int WIDTH     = 5;
  localparam int SWEEP_W   = 8;
  localparam int CNT_MOD   = 1 << WIDTH;
  localparam int SWEEP_MAX = (1 << SWEEP_W) - 1;
  localparam int M_IDLE = 0, M_UP = 1, M_DOWN = 2, M_ERR = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  updown_dir_ctrl_if #(.WIDTH(WIDTH), .SWEEP_W(SWEEP_W)) bus ();

  updown_dir_ctrl #(.WIDTH(WIDTH), .SWEEP_W(SWEEP_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: two most recent samples, last trusted value, sweep mode and outputs.
  int m_s1, m_s2, m_good, m_mode, m_dir, m_pulse, m_sweeps;

  always @(posedge clk or posedge reset) begin : model
    int lo, hi;
    bit ok, top, bot;
`ifdef STEP_CHECK_EN
    int diff;
`endif
    if (reset) begin
      m_s1 = 0; m_s2 = 0; m_good = 0;
      m_mode = M_IDLE; m_dir = 1; m_pulse = 0; m_sweeps = 0;
    end else begin
      lo = int'(bus.lo_lim);
      hi = int'(bus.hi_lim);
`ifdef STEP_CHECK_EN
      diff = (m_s1 - m_s2 + CNT_MOD) % CNT_MOD;
      ok = (diff == 0) || (diff == 1) || (diff == CNT_MOD - 1);
`else
      ok = 1'b1;
`endif
      top = ok && ((m_s1 >= hi) || (m_s2 == CNT_MOD - 1 && m_s1 == 0));
      bot = ok && ((m_s1 <= lo) || (m_s2 == 0 && m_s1 == CNT_MOD - 1));
      m_pulse = 0;
      if (!bus.enable) begin
        m_mode = M_IDLE;
      end else if (lo >= hi) begin
        m_mode = M_ERR;
      end else if (m_mode == M_IDLE) begin
        m_sweeps = 0;
        m_mode = (m_good < hi) ? M_UP : M_DOWN;
        m_dir = (m_mode == M_UP) ? 1 : 0;
      end else if (m_mode == M_ERR) begin
        m_mode = M_IDLE;
      end else if ((m_mode == M_UP && top) || (m_mode == M_DOWN && bot)) begin
        m_mode = (m_mode == M_UP) ? M_DOWN : M_UP;
        m_dir = (m_mode == M_UP) ? 1 : 0;
        m_pulse = 1;
        m_sweeps = (m_sweeps < SWEEP_MAX) ? m_sweeps + 1 : SWEEP_MAX;
      end
      if (ok) m_good = m_s1;
      m_s2 = m_s1;
      m_s1 = int'(bus.count);
    end
  end

  always @(negedge clk) begin
    check("up_down",   bus.up_down,   m_dir);
    check("dir_flip",  bus.dir_flip,  m_pulse);
    check("sweep_cnt", bus.sweep_cnt, m_sweeps);
    check("limit_err", bus.limit_err, (m_mode == M_ERR) ? 1 : 0);
  end

  // Stimulus: an optional bench-side up/down counter following up_down, with glitch injection.
  logic [WIDTH-1:0] ctr;
  bit               follow;
  int               glitch_pct;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      logic ud;
      ud = bus.up_down;
      @(posedge clk);
      if (follow) ctr = ud ? ctr + 1'b1 : ctr - 1'b1;
      @(negedge clk);
      #2;
      if (follow) begin
        if (glitch_pct > 0 && int'($urandom_range(0, 99)) < glitch_pct)
          bus.count = WIDTH'($urandom_range(0, CNT_MOD - 1));
        else
          bus.count = ctr;
      end
    end
  endtask

  initial begin
    int flips, maxc, exp_ud4, exp_sw4, lo_r;
    reset = 1'b1;
    bus.enable = 1'b0; bus.lo_lim = '0; bus.hi_lim = '0; bus.count = '0;
    follow = 1'b0; glitch_pct = 0; ctr = '0;
    @(negedge clk);
    #2;
    step(1);
    check("rst_up_down",   bus.up_down,   1);
    check("rst_dir_flip",  bus.dir_flip,  0);
    check("rst_sweep_cnt", bus.sweep_cnt, 0);
    check("rst_limit_err", bus.limit_err, 0);
    reset = 1'b0;
    step(1);

    // Full round trip lo=4..hi=20 with the counter following up_down.
    bus.lo_lim = 5'd4; bus.hi_lim = 5'd20; ctr = '0; bus.count = '0;
    follow = 1'b1; bus.enable = 1'b1; maxc = 0;
    for (int i = 0; i < 200 && bus.sweep_cnt != 2; i++) begin
      step(1);
      if (int'(ctr) > maxc) maxc = int'(ctr);
    end
    check("t2_sweep_cnt",     bus.sweep_cnt, 2);
    check("t2_up_down",       bus.up_down,   1);
    check("t2_max_overshoot", maxc,          22);

    // Wrap 31->0 seen while sweeping up turns the sweep around exactly once.
    follow = 1'b0; bus.enable = 1'b0; bus.lo_lim = 5'd2; bus.hi_lim = 5'd31;
    bus.count = 5'd30; step(3);
    bus.count = 5'd31; step(1);
    bus.count = 5'd0; bus.enable = 1'b1; flips = 0;
    step(1); flips += int'(bus.dir_flip);
    bus.count = 5'd30;
    repeat (5) begin step(1); flips += int'(bus.dir_flip); end
    check("t3_flips",     flips,         1);
    check("t3_sweep_cnt", bus.sweep_cnt, 1);
    check("t3_up_down",   bus.up_down,   0);

    // Glitch sample 27 between 11 and 12 with hi=25.
    bus.enable = 1'b0; bus.lo_lim = 5'd2; bus.hi_lim = 5'd25; bus.count = 5'd10; step(3);
    bus.enable = 1'b1; step(2);
    bus.count = 5'd11; step(1);
    bus.count = 5'd27; step(1);
    bus.count = 5'd12; step(5);
`ifdef STEP_CHECK_EN
    exp_ud4 = 1; exp_sw4 = 0;
`else
    exp_ud4 = 0; exp_sw4 = 1;
`endif
    check("t4_up_down",   bus.up_down,   exp_ud4);
    check("t4_sweep_cnt", bus.sweep_cnt, exp_sw4);

    // Inverted limits: error with direction frozen, then recovery via IDLE into UP.
    bus.enable = 1'b0; step(1);
    bus.lo_lim = 5'd20; bus.hi_lim = 5'd8; bus.count = 5'd22; bus.enable = 1'b1; step(2);
    check("t5_limit_err", bus.limit_err, 1);
    check("t5_up_down",   bus.up_down,   exp_ud4);
    bus.hi_lim = 5'd25; step(1);
    check("t5_err_clear", bus.limit_err, 0);
    step(1);
    check("t5_reenter_up", bus.up_down, 1);

    // Enable falls in the cycle the upper limit is being acted on.
    bus.count = 5'd25; step(1);
    bus.enable = 1'b0; step(1);
    check("t6_no_flip",   bus.dir_flip,  0);
    check("t6_up_down",   bus.up_down,   1);
    check("t6_sweep_cnt", bus.sweep_cnt, 0);

    // Reset in the middle of a sweep.
    bus.lo_lim = 5'd4; bus.hi_lim = 5'd20; ctr = 5'd5; bus.count = 5'd5;
    follow = 1'b1; bus.enable = 1'b1; step(40);
    reset = 1'b1;
    #1;
    check("t6_rst_up_down",   bus.up_down,   1);
    check("t6_rst_dir_flip",  bus.dir_flip,  0);
    check("t6_rst_sweep_cnt", bus.sweep_cnt, 0);
    check("t6_rst_limit_err", bus.limit_err, 0);
    step(2);
    reset = 1'b0;

    // Narrow band to drive sweep_cnt into saturation.
    bus.lo_lim = 5'd10; bus.hi_lim = 5'd11; ctr = 5'd10; bus.count = 5'd10;
    for (int i = 0; i < 4000 && bus.sweep_cnt != SWEEP_W'(SWEEP_MAX); i++) step(1);
    check("sat_reached", bus.sweep_cnt, SWEEP_MAX);
    flips = 0;
    repeat (20) begin step(1); flips += int'(bus.dir_flip); end
    check("sat_held",      bus.sweep_cnt, SWEEP_MAX);
    check("sat_flip_seen", (flips > 0) ? 1 : 0, 1);

    // Randomized: glitches, enable toggles, limit changes (some invalid), occasional reset.
    glitch_pct = 10;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 2) bus.enable = ~bus.enable;
      if ($urandom_range(0, 99) < 2) begin
        if ($urandom_range(0, 3) != 0) begin
          lo_r = int'($urandom_range(0, 24));
          bus.lo_lim = WIDTH'(lo_r);
          bus.hi_lim = WIDTH'(lo_r + int'($urandom_range(1, 31 - lo_r)));
        end else begin
          bus.lo_lim = WIDTH'($urandom_range(0, CNT_MOD - 1));
          bus.hi_lim = WIDTH'($urandom_range(0, CNT_MOD - 1));
        end
      end
      if ($urandom_range(0, 999) < 3) begin
        reset = 1'b1;
        step(1);
        reset = 1'b0;
      end
      step(1);
    end
    glitch_pct = 0;
    follow = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
